// File: rtl/rijndael_inv_subbytes_iter.sv
// Iterative InvSubBytes: LANES shared inverse S-boxes sweep the captured state, one group per cycle.
// Optional RIJNDAEL_INVSB_FWD_EN adds a per-transaction `inverse` select and forward S-boxes.
package rijndael_gf_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero for free.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction
endpackage

module rijndael_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  import rijndael_gf_pkg::*;
  logic [7:0] b;
  assign b   = gf_inv(a_i);
  assign y_o = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
endmodule

module rijndael_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  import rijndael_gf_pkg::*;
  logic [7:0] b;
  assign b   = rotl(a_i, 1) ^ rotl(a_i, 3) ^ rotl(a_i, 6) ^ 8'h05;
  assign y_o = gf_inv(b);
endmodule

module rijndael_inv_subbytes_iter #(
  parameter int NB    = 4,
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_state
`ifdef RIJNDAEL_INVSB_FWD_EN
  ,
  input  logic              inverse
`endif
);
  localparam int STATESIZE = 32 * NB;
  localparam int NUMBYTES  = 4 * NB;
  localparam int GROUPS    = NUMBYTES / LANES;
  localparam int IDXW      = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(GROUPS - 1);

  if (LANES < 1 || (NUMBYTES % LANES) != 0) begin : g_bad_lanes
    $error("LANES must divide NUMBYTES");
  end
  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("NB must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e               state_q;
  logic [IDXW-1:0]      idx_q;
  logic [STATESIZE-1:0] work_q, work_d;
  logic                 in_ready_q, out_valid_q;
  logic [8*LANES-1:0]   lane_in, lane_out;
`ifdef RIJNDAEL_INVSB_FWD_EN
  logic                 inv_q;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lane_in = '0;
    for (int l = 0; l < LANES; l++)
      lane_in[8*l +: 8] = work_q[8*(int'(idx_q)*LANES + l) +: 8];
  end

  always_comb begin
    work_d = work_q;
    for (int l = 0; l < LANES; l++)
      work_d[8*(int'(idx_q)*LANES + l) +: 8] = lane_out[8*l +: 8];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] inv_y;
    rijndael_inv_sbox u_inv_sbox (.a_i(lane_in[8*l +: 8]), .y_o(inv_y));
`ifdef RIJNDAEL_INVSB_FWD_EN
    logic [7:0] fwd_y;
    rijndael_sbox u_fwd_sbox (.a_i(lane_in[8*l +: 8]), .y_o(fwd_y));
    assign lane_out[8*l +: 8] = inv_q ? inv_y : fwd_y;
`else
    assign lane_out[8*l +: 8] = inv_y;
`endif
  end

  // NOTE: the work register is reset even though it is reloaded on accept, so no X ever reaches out_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef RIJNDAEL_INVSB_FWD_EN
      inv_q       <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          state_q    <= BUSY;
          idx_q      <= '0;
          work_q     <= in_state;
          in_ready_q <= 1'b0;
`ifdef RIJNDAEL_INVSB_FWD_EN
          inv_q      <= inverse;
`endif
        end
        BUSY: begin
          work_q <= work_d;
          idx_q  <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // Partially substituted bytes stay hidden: the work register only shows through while DONE.
  assign out_state = out_valid_q ? work_q : '0;
endmodule

// File: tb/tb_rijndael_inv_subbytes_iter.sv
// Directed bench for rijndael_inv_subbytes_iter: three configurations checked against a table model.
// Build with RIJNDAEL_INVSB_FWD_EN defined to also exercise the forward/inverse select.
module tb_rijndael_inv_subbytes_iter;
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [127:0] in_state_a, out_state_a;
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [255:0] in_state_b, out_state_b;
  logic         in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [191:0] in_state_c, out_state_c;
`ifdef RIJNDAEL_INVSB_FWD_EN
  logic         inverse_a, inverse_b, inverse_c;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] fwd_tab [256];

  rijndael_inv_subbytes_iter #(.NB(4), .LANES(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_state(in_state_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_state(out_state_a)
`ifdef RIJNDAEL_INVSB_FWD_EN
    , .inverse(inverse_a)
`endif
  );
  rijndael_inv_subbytes_iter #(.NB(8), .LANES(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_state(in_state_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_state(out_state_b)
`ifdef RIJNDAEL_INVSB_FWD_EN
    , .inverse(inverse_b)
`endif
  );
  rijndael_inv_subbytes_iter #(.NB(6), .LANES(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_state(in_state_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_state(out_state_c)
`ifdef RIJNDAEL_INVSB_FWD_EN
    , .inverse(inverse_c)
`endif
  );

  function automatic logic [255:0] model(input logic [255:0] s, input int nbytes, input bit inv);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < nbytes; k++)
      r[8*k +: 8] = inv ? INV_SBOX[s[8*k +: 8]] : fwd_tab[s[8*k +: 8]];
    return r;
  endfunction

  function automatic bit rdy(input int w);
    case (w)
      0:       return in_ready_a;
      1:       return in_ready_b;
      default: return in_ready_c;
    endcase
  endfunction

  function automatic bit vld(input int w);
    case (w)
      0:       return out_valid_a;
      1:       return out_valid_b;
      default: return out_valid_c;
    endcase
  endfunction

  function automatic logic [255:0] ost(input int w);
    case (w)
      0:       return {128'b0, out_state_a};
      1:       return out_state_b;
      default: return {64'b0, out_state_c};
    endcase
  endfunction

  task automatic drive_in(input int w, input logic v, input logic [255:0] s);
    case (w)
      0:       begin in_valid_a = v; in_state_a = s[127:0]; end
      1:       begin in_valid_b = v; in_state_b = s;        end
      default: begin in_valid_c = v; in_state_c = s[191:0]; end
    endcase
  endtask

  task automatic set_ordy(input int w, input logic v);
    case (w)
      0:       out_ready_a = v;
      1:       out_ready_b = v;
      default: out_ready_c = v;
    endcase
  endtask

`ifdef RIJNDAEL_INVSB_FWD_EN
  task automatic set_mode(input bit m);
    inverse_a = m; inverse_b = m; inverse_c = m;
  endtask
`endif

  // Present one state, wait for acceptance, then count cycles until out_valid rises.
  task automatic txn(input int w, input logic [255:0] s, output logic [255:0] res,
                     output int lat, output bit tmo);
    int guard;
    guard = 0;
    drive_in(w, 1'b1, s);
    while (!rdy(w) && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    drive_in(w, 1'b0, '0);
    lat = 0;
    while (!vld(w) && lat < 100) begin @(posedge clk); #1; lat++; end
    tmo = !vld(w) || (guard >= 50);
    res = ost(w);
  endtask

  task automatic finish_out(input int w);
    set_ordy(w, 1'b1);
    @(posedge clk); #1;
    set_ordy(w, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_a); end
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_a); end
    checks++; if (out_state_a !== '0) begin failures++; $display("FAIL reset_out_state got=%h exp=0", out_state_a); end
    checks++; if (in_ready_b !== 1'b1 || out_valid_c !== 1'b0) begin failures++;
      $display("FAIL reset_other_duts got=%b%b exp=10", in_ready_b, out_valid_c); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin failures++;
      $display("FAIL post_reset_idle got=%b%b exp=10", in_ready_a, out_valid_a); end
  endtask

  task automatic test_all_63;
    logic [255:0] res; int lat; bit tmo;
    txn(0, {128'b0, {16{8'h63}}}, res, lat, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL all63_timeout got=timeout exp=out_valid"); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL all63_latency got=%0d exp=4", lat); end
    checks++; if (res[127:0] !== 128'h0) begin failures++; $display("FAIL all63_data got=%h exp=0", res[127:0]); end
    checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL all63_in_ready_done got=%b exp=0", in_ready_a); end
    finish_out(0);
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin failures++;
      $display("FAIL all63_handshake got=%b%b exp=01", out_valid_a, in_ready_a); end
  endtask

  task automatic test_table;
    logic [255:0] s, res; int lat; bit tmo;
    s = '0;
    for (int k = 0; k < 16; k++) s[8*k +: 8] = 8'(k);
    txn(0, s, res, lat, tmo);
    checks++; if (tmo || lat !== 4) begin failures++; $display("FAIL table_latency got=%0d exp=4", lat); end
    checks++; if (res[7:0] !== 8'h52) begin failures++; $display("FAIL table_byte0 got=%h exp=52", res[7:0]); end
    checks++; if (res[15:8] !== 8'h09) begin failures++; $display("FAIL table_byte1 got=%h exp=09", res[15:8]); end
    checks++; if (res[127:120] !== 8'hfb) begin failures++; $display("FAIL table_byte15 got=%h exp=fb", res[127:120]); end
    checks++; if (res[127:0] !== model(s, 16, 1'b1)) begin failures++;
      $display("FAIL table_all got=%h exp=%h", res[127:0], model(s, 16, 1'b1)); end
    finish_out(0);
  endtask

  task automatic test_backpressure;
    logic [255:0] s, s2, s3, exp, res; int lat; bit tmo;
    s   = {128'b0, 128'h00112233445566778899aabbccddeeff};
    s2  = {128'b0, {16{8'h63}}};
    s3  = {128'b0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0};
    exp = model(s, 16, 1'b1);
    txn(0, s, res, lat, tmo);
    checks++; if (tmo || res !== exp) begin failures++; $display("FAIL bp_first got=%h exp=%h", res, exp); end
    for (int c = 0; c < 10; c++) begin
      drive_in(0, c == 3, s2);
      @(posedge clk); #1;
      checks++;
      if (out_valid_a !== 1'b1 || out_state_a !== exp[127:0] || in_ready_a !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_c%0d got=%b/%h/%b exp=1/%h/0", c, out_valid_a, out_state_a, in_ready_a, exp[127:0]);
      end
    end
    drive_in(0, 1'b0, '0);
    finish_out(0);
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin failures++;
      $display("FAIL bp_release got=%b%b exp=01", out_valid_a, in_ready_a); end
    txn(0, s3, res, lat, tmo);
    checks++; if (tmo || res !== model(s3, 16, 1'b1)) begin failures++;
      $display("FAIL bp_next_state got=%h exp=%h", res, model(s3, 16, 1'b1)); end
    finish_out(0);
  endtask

  task automatic test_reset_mid_busy;
    logic [255:0] res; int lat; bit tmo; bit seen; int guard;
    guard = 0;
    drive_in(0, 1'b1, {128'b0, 128'hdeadbeef0123456789abcdeffedcba98});
    while (!in_ready_a && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    drive_in(0, 1'b0, '0);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin failures++;
      $display("FAIL rst_busy_outputs got=%b%b exp=01", out_valid_a, in_ready_a); end
    checks++; if (out_state_a !== '0) begin failures++; $display("FAIL rst_busy_state got=%h exp=0", out_state_a); end
    #2 rst_n = 1'b1;
    set_ordy(0, 1'b1);
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (out_valid_a) seen = 1'b1; end
    set_ordy(0, 1'b0);
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_busy_no_output got=%b exp=0", seen); end
    txn(0, {128'b0, {16{8'hed}}}, res, lat, tmo);
    checks++; if (tmo || res[127:0] !== {16{8'h53}}) begin failures++;
      $display("FAIL rst_busy_recover got=%h exp=%h", res[127:0], {16{8'h53}}); end
    finish_out(0);
  endtask

  task automatic test_wide;
    logic [255:0] s, res; int lat; bit tmo;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 8; k++) s[32*k +: 32] = $urandom;
      txn(1, s, res, lat, tmo);
      checks++; if (tmo || lat !== 1) begin failures++; $display("FAIL wide8_latency_t%0d got=%0d exp=1", t, lat); end
      checks++; if (res !== model(s, 32, 1'b1)) begin failures++;
        $display("FAIL wide8_data_t%0d got=%h exp=%h", t, res, model(s, 32, 1'b1)); end
      finish_out(1);
      s[255:192] = '0;
      txn(2, s, res, lat, tmo);
      checks++; if (tmo || lat !== 12) begin failures++; $display("FAIL nb6_latency_t%0d got=%0d exp=12", t, lat); end
      checks++; if (res !== model(s, 24, 1'b1)) begin failures++;
        $display("FAIL nb6_data_t%0d got=%h exp=%h", t, res, model(s, 24, 1'b1)); end
      finish_out(2);
    end
  endtask

`ifdef RIJNDAEL_INVSB_FWD_EN
  task automatic test_fwd;
    logic [255:0] res; int lat; bit tmo;
    set_mode(1'b0);
    txn(0, {128'b0, {16{8'h53}}}, res, lat, tmo);
    checks++; if (tmo || lat !== 4 || res[127:0] !== {16{8'hed}}) begin failures++;
      $display("FAIL fwd_53 got=%h lat=%0d exp=%h lat=4", res[127:0], lat, {16{8'hed}}); end
    finish_out(0);
    set_mode(1'b1);
    txn(0, {128'b0, {16{8'hed}}}, res, lat, tmo);
    checks++; if (tmo || res[127:0] !== {16{8'h53}}) begin failures++;
      $display("FAIL inv_ed got=%h exp=%h", res[127:0], {16{8'h53}}); end
    finish_out(0);
  endtask
`endif

  task automatic test_back_to_back;
    logic [127:0] st [3];
    bit           md [3];
    int           acc_cyc [3];
    int           n_in, n_out;
    bit           acc, hs;
    logic [127:0] o, exp;
    st[0] = 128'h000102030405060708090a0b0c0d0e0f;
    st[1] = 128'h5353535353535353edededededededed;
    st[2] = 128'hffeeddccbbaa99887766554433221100;
`ifdef RIJNDAEL_INVSB_FWD_EN
    md[0] = 1'b1; md[1] = 1'b0; md[2] = 1'b1;
`else
    md[0] = 1'b1; md[1] = 1'b1; md[2] = 1'b1;
`endif
    n_in = 0; n_out = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    set_ordy(0, 1'b1);
    for (int cyc = 0; cyc < 100 && n_out < 3; cyc++) begin
      if (n_in < 3) begin
        drive_in(0, 1'b1, {128'b0, st[n_in]});
`ifdef RIJNDAEL_INVSB_FWD_EN
        set_mode(md[n_in]);
`endif
      end else drive_in(0, 1'b0, '0);
      acc = in_valid_a && in_ready_a;
      hs  = out_valid_a && out_ready_a;
      o   = out_state_a;
      @(posedge clk); #1;
      if (acc) begin acc_cyc[n_in] = cyc; n_in++; end
      if (hs) begin
        exp = model({128'b0, st[n_out]}, 16, md[n_out]);
        checks++; if (o !== exp) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", n_out, o, exp); end
        n_out++;
      end
    end
    set_ordy(0, 1'b0);
    drive_in(0, 1'b0, '0);
    checks++; if (n_out !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n_out); end
    checks++; if (acc_cyc[1] - acc_cyc[0] !== 6) begin failures++;
      $display("FAIL b2b_spacing01 got=%0d exp=6", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (acc_cyc[2] - acc_cyc[1] !== 6) begin failures++;
      $display("FAIL b2b_spacing12 got=%0d exp=6", acc_cyc[2] - acc_cyc[1]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fwd_tab[INV_SBOX[i]] = 8'(i);
    in_valid_a = 1'b0; in_state_a = '0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_state_b = '0; out_ready_b = 1'b0;
    in_valid_c = 1'b0; in_state_c = '0; out_ready_c = 1'b0;
`ifdef RIJNDAEL_INVSB_FWD_EN
    set_mode(1'b1);
`endif
    test_reset;
    test_all_63;
    test_table;
    test_backpressure;
    test_reset_mid_busy;
    test_wide;
`ifdef RIJNDAEL_INVSB_FWD_EN
    test_fwd;
`endif
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
